// File: rtl/hack_rom_loader.sv
// Streams a length-prefixed, checksummed program into the Hack ROM, holding the
// CPU in reset until the load has been verified.
module hack_rom_loader #(
  parameter int ROM_AW = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              rom_we,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [15:0]       rom_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  // state  | meaning
  // IDLE   | waiting for start
  // LEN_HI | expecting word-count high byte
  // LEN_LO | expecting word-count low byte
  // DAT_HI | expecting data word high byte
  // DAT_LO | expecting data word low byte
  // WRITE  | one-cycle ROM write strobe, sum update
  // CS_HI  | expecting checksum high byte
  // CS_LO  | expecting checksum low byte
  // CHECK  | compare received checksum with running sum
  // DONE   | load good, CPU released
  // ERR    | load failed, CPU held in reset
  typedef enum logic [3:0] {
    IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, WRITE, CS_HI, CS_LO, CHECK, DONE, ERR
  } state_t;

  localparam int          IW    = ROM_AW + 1;
  localparam logic [31:0] MAX_N = 32'd1 << ROM_AW;

  state_t              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [7:0]          hi_q, hi_d;
  logic [IW-1:0]       index_q, index_d;
  logic [15:0]         sum_q, sum_d;
  logic [15:0]         csum_q, csum_d;
  logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
  logic [15:0]         rom_wdata_q, rom_wdata_d;
  logic                in_ready_q, in_ready_d;
  logic                rom_we_q, rom_we_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                accept;
  logic [15:0]         len_full;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    hi_d        = hi_q;
    index_d     = index_q;
    sum_d       = sum_q;
    csum_d      = csum_q;
    rom_addr_d  = rom_addr_q;
    rom_wdata_d = rom_wdata_q;
    accept      = in_valid && in_ready_q;
    len_full    = {len_q[15:8], in_data};

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = LEN_HI;
          index_d = '0;
          sum_d   = '0;
        end
      end
      LEN_HI: begin
        if (accept) begin
          len_d[15:8] = in_data;
          state_d     = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_d[7:0] = in_data;
          if (len_full == 16'd0)
            state_d = CS_HI;
          else if (32'(len_full) > MAX_N)
            state_d = ERR;
          else
            state_d = DAT_HI;
        end
      end
      DAT_HI: begin
        if (accept) begin
          hi_d    = in_data;
          state_d = DAT_LO;
        end
      end
      DAT_LO: begin
        // address and word are latched here so they are stable for the whole WRITE cycle
        if (accept) begin
          rom_addr_d  = index_q[ROM_AW-1:0];
          rom_wdata_d = {hi_q, in_data};
          state_d     = WRITE;
        end
      end
      WRITE: begin
        sum_d   = sum_q + rom_wdata_q;
        index_d = index_q + IW'(1);
        if (32'(index_q) + 32'd1 == 32'(len_q))
          state_d = CS_HI;
        else
          state_d = DAT_HI;
      end
      CS_HI: begin
        if (accept) begin
          csum_d[15:8] = in_data;
          state_d      = CS_LO;
        end
      end
      CS_LO: begin
        if (accept) begin
          csum_d[7:0] = in_data;
          state_d     = CHECK;
        end
      end
      CHECK: begin
        state_d = (csum_q == sum_q) ? DONE : ERR;
      end
      default: state_d = IDLE;
    endcase

    // outputs are decoded from the next state so they line up with state_q
    in_ready_d  = state_d inside {LEN_HI, LEN_LO, DAT_HI, DAT_LO, CS_HI, CS_LO};
    rom_we_d    = (state_d == WRITE);
    cpu_reset_d = (state_d != DONE);
    done_d      = (state_d == DONE);
    error_d     = (state_d == ERR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      hi_q        <= '0;
      index_q     <= '0;
      sum_q       <= '0;
      csum_q      <= '0;
      rom_addr_q  <= '0;
      rom_wdata_q <= '0;
      in_ready_q  <= 1'b0;
      rom_we_q    <= 1'b0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      hi_q        <= hi_d;
      index_q     <= index_d;
      sum_q       <= sum_d;
      csum_q      <= csum_d;
      rom_addr_q  <= rom_addr_d;
      rom_wdata_q <= rom_wdata_d;
      in_ready_q  <= in_ready_d;
      rom_we_q    <= rom_we_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign rom_we    = rom_we_q;
  assign rom_addr  = rom_addr_q;
  assign rom_wdata = rom_wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_hack_rom_loader.sv
// Scoreboard bench for hack_rom_loader with a 16-word ROM so oversize and
// full-size loads are cheap to exercise.
module tb_hack_rom_loader;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          rom_we;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_wdata;
  logic          cpu_reset;
  logic          done;
  logic          error;

  int total = 0;
  int bad   = 0;

  logic [AW+15:0] exp_q[$];
  logic [AW+15:0] mon_exp;
  logic [15:0]    prog[$];
  bit             bp_mode    = 1'b0;
  bit             poke_start = 1'b0;

  hack_rom_loader #(.ROM_AW(AW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .rom_we    (rom_we),
    .rom_addr  (rom_addr),
    .rom_wdata (rom_wdata),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  // every ROM write must match the next expected {addr, word}
  always @(negedge clk) begin
    if (rom_we === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rom_write_unexpected got addr=%0h data=%0h expected none", rom_addr, rom_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({rom_addr, rom_wdata} !== mon_exp) begin
          bad++;
          $display("FAIL rom_write got addr=%0h data=%0h expected addr=%0h data=%0h",
                   rom_addr, rom_wdata, mon_exp[AW+15:16], mon_exp[15:0]);
        end
      end
      total++;
      if (in_ready !== 1'b0) begin
        bad++;
        $display("FAIL ready_during_write got %b expected 0", in_ready);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] prog_sum();
    logic [15:0] s;
    s = 16'h0000;
    foreach (prog[i]) s = s + prog[i];
    return s;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n;
    if (bp_mode) begin
      n = $urandom_range(0, 3);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL send_byte_timeout byte=%0h in_ready=%b expected 1", b, in_ready);
    end else begin
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load(input logic [15:0] n, input logic [15:0] cs, input bit good);
    foreach (prog[i]) exp_q.push_back({AW'(i), prog[i]});
    pulse_start();
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    if (poke_start) pulse_start();
    foreach (prog[i]) begin
      send_byte(prog[i][15:8]);
      send_byte(prog[i][7:0]);
    end
    send_byte(cs[15:8]);
    send_byte(cs[7:0]);
    total++;
    if ({done, error, cpu_reset} !== 3'b001) begin
      bad++;
      $display("FAIL check_cycle got done=%b error=%b cpu_reset=%b expected 0 0 1", done, error, cpu_reset);
    end
    @(negedge clk);
    total++;
    if ({done, error, cpu_reset} !== (good ? 3'b100 : 3'b011)) begin
      bad++;
      $display("FAIL load_result got done=%b error=%b cpu_reset=%b expected good=%b", done, error, cpu_reset, good);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_writes got %0d pending expected 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    total++;
    if ({in_ready, rom_we, rom_addr, rom_wdata, cpu_reset, done, error} !==
        {1'b0, 1'b0, {AW{1'b0}}, 16'h0000, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_values got rdy=%b we=%b addr=%0h data=%0h cpu_rst=%b done=%b err=%b",
               in_ready, rom_we, rom_addr, rom_wdata, cpu_reset, done, error);
    end
    reset_n  = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (3) @(negedge clk);
    total++;
    if ({in_ready, cpu_reset, done, error} !== 4'b0100) begin
      bad++;
      $display("FAIL idle_hold got rdy=%b cpu_rst=%b done=%b err=%b expected 0 1 0 0",
               in_ready, cpu_reset, done, error);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_good_load();
    prog = '{16'h1234, 16'hABCD};
    load(16'h0002, 16'hBE01, 1'b1);
    total++;
    if ({rom_addr, rom_wdata} !== {AW'(1), 16'hABCD}) begin
      bad++;
      $display("FAIL rom_hold got addr=%0h data=%0h expected 1 abcd", rom_addr, rom_wdata);
    end
  endtask

  task automatic test_bad_checksum();
    prog = '{16'h1234, 16'hABCD};
    load(16'h0002, 16'hBE02, 1'b0);
  endtask

  task automatic test_empty();
    prog.delete();
    load(16'h0000, 16'h0000, 1'b1);
  endtask

  task automatic test_backpressure();
    bp_mode = 1'b1;
    prog = '{16'h1234, 16'hABCD};
    load(16'h0002, 16'hBE01, 1'b1);
    bp_mode = 1'b0;
  endtask

  task automatic test_start_ignored();
    poke_start = 1'b1;
    prog = '{16'h0005};
    load(16'h0001, 16'h0005, 1'b1);
    poke_start = 1'b0;
  endtask

  task automatic test_oversize();
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h11);
    total++;
    if ({error, done, cpu_reset, in_ready} !== 4'b1010) begin
      bad++;
      $display("FAIL oversize got err=%b done=%b cpu_rst=%b rdy=%b expected 1 0 1 0",
               error, done, cpu_reset, in_ready);
    end
    in_valid = 1'b1;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (error !== 1'b1) begin
      bad++;
      $display("FAIL err_hold got %b expected 1", error);
    end
    prog = '{16'h1234, 16'hABCD};
    load(16'h0002, 16'hBE01, 1'b1);
  endtask

  task automatic test_max_size();
    prog.delete();
    for (int i = 0; i < (1 << AW); i++) prog.push_back(16'hF000 + 16'(i));
    load(16'(1 << AW), prog_sum(), 1'b1);
    total++;
    if (rom_addr !== {AW{1'b1}}) begin
      bad++;
      $display("FAIL max_last_addr got %0h expected %0h", rom_addr, {AW{1'b1}});
    end
  endtask

  task automatic test_reset_midload();
    exp_q.push_back({AW'(0), 16'h1234});
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'hAB);
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({in_ready, rom_we, rom_addr, rom_wdata, cpu_reset, done, error} !==
        {1'b0, 1'b0, {AW{1'b0}}, 16'h0000, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL async_reset got rdy=%b we=%b addr=%0h data=%0h cpu_rst=%b done=%b err=%b",
               in_ready, rom_we, rom_addr, rom_wdata, cpu_reset, done, error);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL midload_writes got %0d pending expected 0", exp_q.size());
    end
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    prog = '{16'h1234, 16'hABCD};
    load(16'h0002, 16'hBE01, 1'b1);
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_empty();
    test_backpressure();
    test_start_ignored();
    test_oversize();
    test_max_size();
    test_reset_midload();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
